// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the div_ctrl stage that sits in front of the
// 16-bit signed divider. Optional statistics build: DIV_CTRL_STATS_EN.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  localparam int unsigned WIDTH_C = 16;

  localparam logic [WIDTH_C-1:0] DBZ_QUOTIENT = 16'hFFFF;
  localparam logic [WIDTH_C-1:0] MIN_NEG      = 16'h8000;
  localparam logic [WIDTH_C-1:0] NEG_ONE      = 16'hFFFF;

  // The one signed pair whose true quotient does not fit in WIDTH_C bits.
  function automatic logic is_overflow(input logic [WIDTH_C-1:0] dividend,
                                       input logic [WIDTH_C-1:0] divisor);
    return (dividend == MIN_NEG) && (divisor == NEG_ONE);
  endfunction

endpackage

// File: rtl/div_ctrl_stats.sv
// Saturating operation / divide-by-zero counters for div_ctrl.
// Only present when DIV_CTRL_STATS_EN is defined.
`ifdef DIV_CTRL_STATS_EN
module div_ctrl_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_i,
  input  logic        dbz_i,
  output logic [15:0] ops_o,
  output logic [15:0] dbz_o
);

  logic [15:0] ops_q;
  logic [15:0] dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= '0;
      dbz_q <= '0;
    end else if (hs_i) begin
      if (ops_q != '1) ops_q <= ops_q + 16'd1;
      if (dbz_i && (dbz_q != '1)) dbz_q <= dbz_q + 16'd1;
    end
  end

  assign ops_o = ops_q;
  assign dbz_o = dbz_q;

endmodule
`endif

// File: rtl/div_ctrl.sv
// Multicycle control stage for the external 16-bit combinational signed divider.
// Define DIV_CTRL_STATS_EN to build the saturating stat_ops/stat_dbz counters.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_m,
  input  logic [WIDTH-1:0] div_quo,
  input  logic [WIDTH-1:0] div_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_dbz
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q_q, div_q_d;
  logic [WIDTH-1:0] div_m_q, div_m_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q_q <= '0;
      div_m_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q_q <= div_q_d;
      div_m_q <= div_m_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Special cases preload the result and pass through SETTLE with the counter
  // at 0, which gives them their one-cycle latency; a set flag marks the
  // result as already final so the divider outputs are not captured.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_q_d   = div_q_q;
    div_m_d   = div_m_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          div_q_d = in_dividend;
          div_m_d = in_divisor;
          state_d = SETTLE;
          if (in_divisor == '0) begin
            quo_d = DBZ_QUOTIENT;
            rem_d = in_dividend;
            dbz_d = 1'b1;
            ovf_d = 1'b0;
            cnt_d = '0;
          end else if (is_overflow(in_dividend, in_divisor)) begin
            quo_d = MIN_NEG;
            rem_d = '0;
            dbz_d = 1'b0;
            ovf_d = 1'b1;
            cnt_d = '0;
          end else begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            cnt_d = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (!(dbz_q || ovf_q)) begin
            quo_d = div_quo;
            rem_d = div_rem;
          end
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_q         = div_q_q;
  assign div_m         = div_m_q;
  assign out_quotient  = quo_q;
  assign out_remainder = rem_q;
  assign out_dbz       = dbz_q;
  assign out_ovf       = ovf_q;

`ifdef DIV_CTRL_STATS_EN
  logic out_hs;
  assign out_hs = (state_q == HOLD) && out_ready;

  div_ctrl_stats u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .hs_i  (out_hs),
    .dbz_i (dbz_q),
    .ops_o (stat_ops),
    .dbz_o (stat_dbz)
  );
`else
  assign stat_ops = '0;
  assign stat_dbz = '0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural divider attached and a
// reference model built from signed integer arithmetic.
module tb_div_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned SC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic [W-1:0] div_q, div_m, div_quo, div_rem;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quotient, out_remainder;
  logic         out_dbz, out_ovf;
  logic [15:0]  stat_ops, stat_dbz;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned exp_ops = 0;
  int unsigned exp_dbz = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_q         (div_q),
    .div_m         (div_m),
    .div_quo       (div_quo),
    .div_rem       (div_rem),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz),
    .out_ovf       (out_ovf),
    .stat_ops      (stat_ops),
    .stat_dbz      (stat_dbz)
  );

  // Behavioural divider: junk on a zero divisor so an unhandled case shows up.
  always_comb begin
    if (div_m == '0) begin
      div_quo = 16'hDEAD;
      div_rem = 16'hBEEF;
    end else begin
      div_quo = 16'(int'($signed(div_q)) / int'($signed(div_m)));
      div_rem = 16'(int'($signed(div_q)) % int'($signed(div_m)));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output logic ovf);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dbz = 1'b0;
    ovf = 1'b0;
    if (sb == 0) begin
      q = 16'hFFFF; r = a; dbz = 1'b1;
    end else if (sa == -32768 && sb == -1) begin
      q = 16'h8000; r = 16'h0000; ovf = 1'b1;
    end else begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef DIV_CTRL_STATS_EN
    return (v > 32'hFFFF) ? 32'hFFFF : v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int unsigned hold);
    logic [15:0] eq, er;
    logic ed, eo;
    int unsigned lat, waitc;
    ref_div(a, b, eq, er, ed, eo);
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_dividend = 16'($urandom);
    in_divisor = 16'($urandom);
    check("div_q_load", {16'd0, div_q}, {16'd0, a});
    check("div_m_load", {16'd0, div_m}, {16'd0, b});
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (ed || eo) ? 32'd1 : SC);
    check("quotient", {16'd0, out_quotient}, {16'd0, eq});
    check("remainder", {16'd0, out_remainder}, {16'd0, er});
    check("dbz", {31'd0, out_dbz}, {31'd0, ed});
    check("ovf", {31'd0, out_ovf}, {31'd0, eo});
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_dividend = 16'($urandom);
      in_divisor = 16'($urandom);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_quotient", {16'd0, out_quotient}, {16'd0, eq});
      check("hold_div_q", {16'd0, div_q}, {16'd0, a});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops++;
    if (ed) exp_dbz++;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("stat_ops", {16'd0, stat_ops}, exp_stat(exp_ops));
    check("stat_dbz", {16'd0, stat_dbz}, exp_stat(exp_dbz));
  endtask

  initial begin
    logic [15:0] ra, rb;
    int unsigned kind;

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, out_quotient}, 32'd0);
    check("rst_div_q", {16'd0, div_q}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_flags", {30'd0, out_dbz, out_ovf}, 32'd0);
    check("rel_stat_ops", {16'd0, stat_ops}, 32'd0);

    do_op(16'd100, 16'd7, 0);
    check("q_100_7", {16'd0, out_quotient}, 32'd14);
    check("r_100_7", {16'd0, out_remainder}, 32'd2);
    do_op(16'hFF9C, 16'd7, 0);
    check("q_m100_7", {16'd0, out_quotient}, 32'h0000FFF2);
    check("r_m100_7", {16'd0, out_remainder}, 32'h0000FFFE);
    do_op(16'd100, 16'hFFF9, 1);
    do_op(16'd1234, 16'd0, 0);
    check("r_1234_0", {16'd0, out_remainder}, 32'd1234);
    do_op(16'h8000, 16'hFFFF, 2);
    do_op(16'd100, 16'd7, 10);

    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_no_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ready_stat", {16'd0, stat_ops}, exp_stat(exp_ops));

    in_valid = 1'b1;
    in_dividend = 16'd100;
    in_divisor = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_div_q", {16'd0, div_q}, 32'd0);
    check("abort_quotient", {16'd0, out_quotient}, 32'd0);
    exp_ops = 0;
    exp_dbz = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SC + 2) begin
      @(negedge clk);
      check("post_abort_valid", {31'd0, out_valid}, 32'd0);
    end
    do_op(16'd50, 16'd5, 0);
    check("q_50_5", {16'd0, out_quotient}, 32'd10);
    check("r_50_5", {16'd0, out_remainder}, 32'd0);

    for (int unsigned n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 7);
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (kind)
        0: rb = 16'h0000;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = 16'hFFFF;
        3: begin ra = 16'h8000; rb = 16'($urandom_range(1, 3)); end
        4: rb = 16'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
